// File: rtl/sram_port_arbiter.sv
// Arbitrates a single-port synchronous SRAM between instruction fetch and data memory.
// Data wins by default; a starvation counter forces an instruction grant after
// STARVE_LIMIT consecutive denied cycles. Read data is routed back to the port
// that owned the read issued in the previous cycle.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t           rsp_owner;
    owner_t           rsp_owner_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             force_inst;

    assign force_inst = (starve_cnt == CNT_MAX);

    // Grant selection: data by default, instruction when only it requests or is starved.
    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (!reset) begin
            if (inst_req && (!data_req || force_inst)) begin
                inst_gnt = 1'b1;
            end else if (data_req) begin
                data_gnt = 1'b1;
            end
        end
    end

    // SRAM request mux driven from the winning port; idle bus is all zeros.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (inst_gnt) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (data_gnt) begin
            sram_en    = 1'b1;
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    // Next starvation count: count denied instruction cycles, saturating.
    always_comb begin
        starve_cnt_next = '0;
        if (inst_req && !inst_gnt) begin
            starve_cnt_next = force_inst ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    // Next response owner: only reads produce a response.
    always_comb begin
        rsp_owner_next = OWN_NONE;
        if (inst_gnt) begin
            rsp_owner_next = OWN_INST;
        end else if (data_gnt && (data_we == 4'b0000)) begin
            rsp_owner_next = OWN_DATA;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rsp_owner  <= OWN_NONE;
        end else begin
            starve_cnt <= starve_cnt_next;
            rsp_owner  <= rsp_owner_next;
        end
    end

    // Response routing; suppressed while reset is held so a read granted just before is dropped.
    always_comb begin
        inst_rvalid = !reset && (rsp_owner == OWN_INST);
        data_rvalid = !reset && (rsp_owner == OWN_DATA);
        inst_rdata  = inst_rvalid ? sram_rdata : 32'h0;
        data_rdata  = data_rvalid ? sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed stimulus pushes expected grant/bus
// values and expected read responses; a negedge monitor pops and compares.
module tb_sram_port_arbiter;

    localparam logic [31:0] ADDR_I0 = 32'h1c000000;
    localparam logic [31:0] ADDR_W  = 32'h1c001000;
    localparam logic [31:0] ADDR_A  = 32'h1c002000;
    localparam logic [31:0] ADDR_B  = 32'h1c000040;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ig;
        logic        dg;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        int          cyc;
        int          port;   // 1 = inst, 2 = data
        logic [31:0] data;
    } rexp_t;

    gexp_t gnt_q[$];
    rexp_t rsp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit started = 1'b0;

    int          pend_port = 0;
    logic [31:0] pend_data = 32'h0;

    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: 1-cycle read latency, byte-enabled writes, junk when idle.
    always @(posedge clk) begin
        if (sram_en && sram_we == 4'b0000) begin
            sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
        end else begin
            sram_rdata <= 32'hdead_0000 | 32'(cyc & 16'hffff);
            if (sram_en) begin
                logic [31:0] w;
                w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                end
                mem[sram_addr] = w;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare grant/bus every cycle and route responses against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                gexp_t g;
                g = gnt_q.pop_front();
                chk("inst_gnt",   32'(inst_gnt),   32'(g.ig));
                chk("data_gnt",   32'(data_gnt),   32'(g.dg));
                chk("sram_en",    32'(sram_en),    32'(g.en));
                chk("sram_we",    32'(sram_we),    32'(g.we));
                chk("sram_addr",  sram_addr,       g.addr);
                chk("sram_wdata", sram_wdata,      g.wd);
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                rexp_t r;
                r = rsp_q.pop_front();
                chk("inst_rvalid", 32'(inst_rvalid), 32'(r.port == 1));
                chk("data_rvalid", 32'(data_rvalid), 32'(r.port == 2));
                chk("inst_rdata",  inst_rdata, (r.port == 1) ? r.data : 32'h0);
                chk("data_rdata",  data_rdata, (r.port == 2) ? r.data : 32'h0);
            end else begin
                chk("idle_inst_rvalid", 32'(inst_rvalid), 32'h0);
                chk("idle_data_rvalid", 32'(data_rvalid), 32'h0);
                chk("idle_inst_rdata",  inst_rdata, 32'h0);
                chk("idle_data_rdata",  data_rdata, 32'h0);
            end
        end
    end

    // One cycle of stimulus plus its hand-computed expectations.
    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic eig, input logic edg,
                        input logic [31:0] erd);
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        reset      = rst;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_we    = dwe;
        data_addr  = da;
        data_wdata = dwd;
        started    = 1'b1;

        g.cyc = cyc; g.ig = eig; g.dg = edg; g.en = eig | edg;
        g.we = 4'b0; g.addr = 32'h0; g.wd = 32'h0;
        if (eig) begin
            g.addr = ia;
        end else if (edg) begin
            g.we = dwe; g.addr = da; g.wd = dwd;
        end
        gnt_q.push_back(g);

        if (pend_port != 0 && !rst) begin
            r.cyc = cyc; r.port = pend_port; r.data = pend_data;
            rsp_q.push_back(r);
        end
        pend_port = 0;
        pend_data = erd;
        if (!rst) begin
            if (eig) pend_port = 1;
            else if (edg && dwe == 4'b0000) pend_port = 2;
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Both ports request reads continuously: data reads A, inst reads B.
    task automatic both(input logic eig);
        step(1'b0, 1'b1, ADDR_B, 1'b1, 4'h0, ADDR_A, 32'h0, eig, !eig,
             eig ? 32'h22222222 : 32'h11111111);
    endtask

    initial begin
        mem[ADDR_I0] = 32'h02800c21;
        mem[ADDR_W]  = 32'hffffffff;
        mem[ADDR_A]  = 32'h11111111;
        mem[ADDR_B]  = 32'h22222222;
        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0;
        data_we = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;

        // Reset: no grants even with both requesting.
        idle(1'b1);
        step(1'b1, 1'b1, ADDR_B, 1'b1, 4'h0, ADDR_A, 32'h0, 1'b0, 1'b0, 32'h0);
        // Instruction read and its response.
        step(1'b0, 1'b1, ADDR_I0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800c21);
        idle(1'b0);
        // Partial data write: no response; read back merged word.
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, ADDR_W, 32'h0000beef, 1'b0, 1'b1, 32'h0);
        idle(1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, ADDR_W, 32'h0, 1'b0, 1'b1, 32'hffffbeef);
        // Alternating data then inst reads back to back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, ADDR_A, 32'h0, 1'b0, 1'b1, 32'h11111111);
        step(1'b0, 1'b1, ADDR_B, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h22222222);
        idle(1'b0);
        // Contention: data x4, inst forced, repeating.
        for (int k = 0; k < 10; k++) both(k % 5 == 4);
        idle(1'b0);
        // Inst drops after 3 denied cycles: counter restarts.
        for (int k = 0; k < 3; k++) both(1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, ADDR_A, 32'h0, 1'b0, 1'b1, 32'h11111111);
        for (int k = 0; k < 5; k++) both(k == 4);
        idle(1'b0);
        // Reset right after an inst grant drops the response.
        step(1'b0, 1'b1, ADDR_I0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800c21);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        for (int k = 0; k < 5; k++) both(k == 4);
        // Reset with a partially built starvation count clears it.
        for (int k = 0; k < 3; k++) both(1'b0);
        step(1'b1, 1'b1, ADDR_B, 1'b1, 4'h0, ADDR_A, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) both(k == 4);
        idle(1'b0);
        idle(1'b0);

        @(posedge clk);
        @(negedge clk);
        chk("gnt_q_drained", 32'(gnt_q.size()), 32'h0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the data-memory requester.
- Data wins by default. A starvation counter forces an instruction grant after STARVE_LIMIT consecutive denied cycles.
- Tracks the owner of each outstanding read and routes the SRAM read data back to the correct requester with a valid pulse.
- Sits between the fetch/memory stages and the unified SRAM.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles inst_req may be denied before the instruction port is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction read request
- inst_addr  in  32  instruction byte address
- inst_gnt  out  1  instruction request accepted this cycle
- inst_rvalid  out  1  inst_rdata valid (cycle after inst_gnt)
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_we  in  4  byte write enables; 4'b0000 means read
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_gnt  out  1  data request accepted this cycle
- data_rvalid  out  1  data_rdata valid (cycle after a read grant)
- data_rdata  out  32  data read data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data; valid the cycle after an enabled read

Behaviour:
- State:
  - starve_cnt, 4 bits.
  - rsp_owner ∈ {NONE, INST, DATA}.
- Grant logic (combinational, same cycle as request):
  - reset=1: inst_gnt=0, data_gnt=0.
  - Only inst_req: inst_gnt=1.
  - Only data_req: data_gnt=1.
  - Both, starve_cnt < STARVE_LIMIT: data_gnt=1, inst_gnt=0.
  - Both, starve_cnt == STARVE_LIMIT: inst_gnt=1, data_gnt=0.
  - At most one grant per cycle. A requester holds req and its address/data stable until its grant.
- SRAM drive:
  - inst granted: en=1, we=0, addr=inst_addr, wdata=0.
  - data granted: en=1, we=data_we, addr=data_addr, wdata=data_wdata.
  - No grant: en=0, we=0, addr=0, wdata=0.
- starve_cnt update (posedge):
  - reset: 0.
  - inst_req && !inst_gnt: increment, saturating at STARVE_LIMIT.
  - Otherwise (granted or not requesting): 0.
- rsp_owner update (posedge):
  - reset: NONE.
  - Otherwise: INST if inst_gnt; DATA if data_gnt && data_we==0; NONE in all other cases, including data writes.
- Response outputs:
  - inst_rvalid = (rsp_owner==INST); data_rvalid = (rsp_owner==DATA).
  - Each rdata = sram_rdata when its rvalid=1, else 0.
  - Read latency is exactly 1 cycle from grant. Back-to-back reads are supported, one per cycle; the requester cannot stall a response.
- Writes: complete in the grant cycle and never produce rvalid.
- Reset values: all outputs 0, because rsp_owner=NONE and grants are forced low.
- Reset mid-operation: a read granted in the cycle before reset is dropped; no rvalid in the cycle after reset deasserts.
- Simultaneous events: in a forced-inst cycle the data port is simply not granted and retries. Data has no starvation guard by design, since inst is re-throttled after each forced win.
- Address alignment is not checked; bits [1:0] pass through unchanged.

Test Plan:
- Reset → all outputs 0. Then inst_req=1, inst_addr=0x1c000000 → inst_gnt=1, sram_en=1, sram_addr=0x1c000000. Next cycle sram_rdata=0x02800c21 → inst_rvalid=1, inst_rdata=0x02800c21, data_rvalid=0.
- Data write: data_req=1, data_we=4'b0011, data_addr=0x1c001000, data_wdata=0x0000beef → data_gnt=1, sram_we=4'b0011, sram_wdata=0x0000beef; no rvalid in the following cycle.
- Contention, STARVE_LIMIT=4, both requests held continuously → data_gnt for cycles 0-3, inst_gnt in cycle 4, starve_cnt returns to 0, data_gnt again cycles 5-8; the pattern repeats every 5 cycles.
- Alternating grants: data read (rdata 0x11111111) then inst read (rdata 0x22222222) → data_rvalid at cycle+1 with 0x11111111, inst_rvalid at cycle+2 with 0x22222222; no cross-routing.
- inst_req drops after 3 denied cycles, then reasserts alongside data_req → starve_cnt restarts at 0; data wins for 4 more cycles before inst is forced.
- Reset asserted the cycle after an inst grant → inst_rvalid=0 throughout and after reset; starve_cnt=0.
